// File: rtl/relop_sweep_checker.sv
// Sweeps every (A,B) operand pair into a relational comparator and checks its six flags.
// Latency: SETTLE+1 cycles per vector, 2^(2*WIDTH)*(SETTLE+1) cycles per full sweep.
// Backpressure: none; start is ignored while busy, abort always wins and returns to idle.
module relop_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [5:0]           flags_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [5:0]           fail_flags
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [2*WIDTH-1:0] VEC_ONE     = (2*WIDTH)'(1);
    localparam logic [2*WIDTH:0]   ERR_ONE     = (2*WIDTH+1)'(1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  settle_cnt;
    logic [5:0]  exp_flags;
    logic        mismatch;
    logic        last_vec;
    logic        launch;

    // Reference flags for the vector currently on the bus, plus sweep control decodes
    always_comb begin
        exp_flags = {a_out == b_out, a_out != b_out, a_out > b_out,
                     a_out < b_out,  a_out >= b_out, a_out <= b_out};
        mismatch  = (flags_in != exp_flags);
        last_vec  = (&a_out) && (&b_out);
        launch    = start && !abort && (state == S_IDLE || state == S_DONE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; abort overrides every transition
    always_comb begin
        state_nxt = state;
        busy      = (state == S_WAIT) || (state == S_CHECK);
        done      = (state == S_DONE);
        pass      = (state == S_DONE) && (err_count == '0);
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) state_nxt = S_WAIT;
                S_WAIT:         if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
                S_CHECK:        state_nxt = last_vec ? S_DONE : S_WAIT;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    // Operand sweep, settle timing, error counting and first-failure capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out      <= '0;
            b_out      <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_flags <= '0;
        end else if (launch) begin
            a_out      <= '0;
            b_out      <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_flags <= '0;
        end else if (!abort) begin
            case (state)
                S_WAIT: settle_cnt <= settle_cnt + 4'd1;
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + ERR_ONE;
                        // err_count was cleared at start, so zero here means first failure
                        if (err_count == '0) begin
                            fail_a     <= a_out;
                            fail_b     <= b_out;
                            fail_flags <= flags_in ^ exp_flags;
                        end
                    end
                    if (!last_vec) begin
                        // B is the low half so its wrap carries into A
                        {a_out, b_out} <= {a_out, b_out} + VEC_ONE;
                        settle_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_relop_sweep_checker.sv
module tb_relop_sweep_checker;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       start3 = 1'b0;
    logic       abort3 = 1'b0;
    logic [3:0] a_out, b_out, fail_a, fail_b;
    logic [3:0] a3, b3, fa3, fb3;
    logic [5:0] flags_in, fail_flags, flags3, ff3;
    logic       busy, done, pass, busy3, done3, pass3;
    logic [8:0] err_count, err3;
    int         fault_mode = 0;
    int         checks = 0;
    int         errors = 0;
    vec_t       exp_q[$];

    always #5 clk = ~clk;

    relop_sweep_checker #(.WIDTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_out(a_out), .b_out(b_out), .flags_in(flags_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_a(fail_a), .fail_b(fail_b), .fail_flags(fail_flags)
    );

    relop_sweep_checker #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .a_out(a3), .b_out(b3), .flags_in(flags3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_a(fa3), .fail_b(fb3), .fail_flags(ff3)
    );

    function automatic logic [5:0] cmp_model(input logic [3:0] a, input logic [3:0] b);
        return {a == b, a != b, a > b, a < b, a >= b, a <= b};
    endfunction

    // Comparator under test: golden, gt stuck at 0, or eq/neq swapped
    always_comb begin
        flags_in = cmp_model(a_out, b_out);
        if (fault_mode == 1) flags_in[3] = 1'b0;
        else if (fault_mode == 2) flags_in[5:4] = {flags_in[4], flags_in[5]};
        flags3 = cmp_model(a3, b3);
    end

    task automatic push_sweep();
        exp_q.delete();
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                exp_q.push_back('{a: 4'(a), b: 4'(b)});
    endtask

    task automatic start_dut();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Counts busy cycles; optionally checks each vector (held 2 cycles) against the queue
    task automatic run_to_done(input bit chk_order, output int cyc);
        int   phase;
        vec_t e;
        cyc   = 0;
        phase = 0;
        while (busy && cyc < 2000) begin
            if (chk_order) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL order: got a=%0d b=%0d, expected queue empty", a_out, b_out);
                end else begin
                    e = exp_q[0];
                    if ({a_out, b_out} !== e) begin
                        errors++;
                        $display("FAIL order: got a=%0d b=%0d, expected a=%0d b=%0d",
                                 a_out, b_out, e.a, e.b);
                    end
                    if (phase == 1) void'(exp_q.pop_front());
                end
                phase ^= 1;
            end
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL timeout: sweep still busy after %0d cycles", cyc);
        end
        if (chk_order) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL order_len: %0d vectors not seen, expected 0", exp_q.size());
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({a_out, b_out, err_count, fail_a, fail_b, fail_flags, busy, done, pass} !== '0) begin
            errors++;
            $display("FAIL reset: a=%0d b=%0d err=%0d fa=%0d fb=%0d ff=%b busy=%b done=%b pass=%b, expected all 0",
                     a_out, b_out, err_count, fail_a, fail_b, fail_flags, busy, done, pass);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_golden();
        int cyc;
        fault_mode = 0;
        push_sweep();
        start_dut();
        run_to_done(1'b1, cyc);
        checks++;
        if (cyc != 512) begin
            errors++;
            $display("FAIL golden_cycles: got %0d, expected 512", cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 9'd0) begin
            errors++;
            $display("FAIL golden_result: done=%b pass=%b err=%0d, expected 1 1 0", done, pass, err_count);
        end
        checks++;
        if (a_out !== 4'd15 || b_out !== 4'd15) begin
            errors++;
            $display("FAIL golden_hold: a=%0d b=%0d, expected 15 15", a_out, b_out);
        end
    endtask

    task automatic test_gt_stuck();
        int cyc;
        fault_mode = 1;
        start_dut();
        run_to_done(1'b0, cyc);
        checks++;
        if (err_count !== 9'd120 || pass !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL gt_stuck_count: err=%0d pass=%b done=%b, expected 120 0 1", err_count, pass, done);
        end
        checks++;
        if (fail_a !== 4'd1 || fail_b !== 4'd0 || fail_flags !== 6'b001000) begin
            errors++;
            $display("FAIL gt_stuck_first: fa=%0d fb=%0d ff=%b, expected 1 0 001000", fail_a, fail_b, fail_flags);
        end
    endtask

    task automatic test_eq_neq_swap();
        int cyc;
        fault_mode = 2;
        start_dut();
        run_to_done(1'b0, cyc);
        checks++;
        if (err_count !== 9'd256 || pass !== 1'b0) begin
            errors++;
            $display("FAIL swap_count: err=%0d pass=%b, expected 256 0", err_count, pass);
        end
        checks++;
        if (fail_a !== 4'd0 || fail_b !== 4'd0 || fail_flags !== 6'b110000) begin
            errors++;
            $display("FAIL swap_first: fa=%0d fb=%0d ff=%b, expected 0 0 110000", fail_a, fail_b, fail_flags);
        end
    endtask

    task automatic test_abort();
        int cyc;
        fault_mode = 2;
        start_dut();
        cyc = 0;
        while (!(a_out == 4'd3 && b_out == 4'd7) && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc >= 1000) begin
            errors++;
            $display("FAIL abort_reach: vector (3,7) not reached, got a=%0d b=%0d", a_out, b_out);
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b pass=%b, expected 0 0 0", busy, done, pass);
        end
        checks++;
        if (err_count !== 9'd55 || fail_flags !== 6'b110000) begin
            errors++;
            $display("FAIL abort_retain: err=%0d ff=%b, expected 55 110000", err_count, fail_flags);
        end
        // start and abort together: abort must win
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        checks++;
        if (busy !== 1'b0 || err_count !== 9'd55) begin
            errors++;
            $display("FAIL abort_wins: busy=%b err=%0d, expected 0 55", busy, err_count);
        end
        fault_mode = 0;
        push_sweep();
        start_dut();
        checks++;
        if (err_count !== 9'd0 || a_out !== 4'd0 || b_out !== 4'd0) begin
            errors++;
            $display("FAIL restart_clear: err=%0d a=%0d b=%0d, expected 0 0 0", err_count, a_out, b_out);
        end
        run_to_done(1'b1, cyc);
        checks++;
        if (cyc != 512 || pass !== 1'b1) begin
            errors++;
            $display("FAIL restart_sweep: cycles=%0d pass=%b, expected 512 1", cyc, pass);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        fault_mode = 0;
        start_dut();
        cyc = 0;
        while (busy && cyc < 2000) begin
            start = (cyc == 50 || cyc == 300 || cyc == 511);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (cyc != 512 || done !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: cycles=%0d done=%b, expected 512 1", cyc, done);
        end
    endtask

    task automatic test_reset_mid();
        fault_mode = 2;
        start_dut();
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err_count == 9'd0) begin
            errors++;
            $display("FAIL mid_pre: busy=%b err=%0d, expected busy 1 and errors counted", busy, err_count);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out, b_out, err_count, fail_a, fail_b, fail_flags, busy, done, pass} !== '0) begin
            errors++;
            $display("FAIL mid_reset: a=%0d b=%0d err=%0d ff=%b busy=%b, expected all 0",
                     a_out, b_out, err_count, fail_flags, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_noresume: busy=%b, expected 0", busy);
        end
        fault_mode = 0;
    endtask

    task automatic test_settle3();
        int cyc;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        cyc = 0;
        while (busy3 && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc != 1024 || done3 !== 1'b1 || pass3 !== 1'b1 || err3 !== 9'd0) begin
            errors++;
            $display("FAIL settle3: cycles=%0d done=%b pass=%b err=%0d, expected 1024 1 1 0",
                     cyc, done3, pass3, err3);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_gt_stuck();
        test_eq_neq_swap();
        test_abort();
        test_start_while_busy();
        test_reset_mid();
        test_settle3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
